fir_coef_loader: RTL and testbench
==================================

# fir_coef_loader

Serial coefficient writer for the 21-tap FIR filter. It holds a host-writable coefficient buffer, shifts it into the filter's coefficient chain over the filter's `coef_in`/`clk_coef` port, then reads taps 0..15 back through the filter's `sw`/`coef_current` port. A mismatch raises a sticky error. The block sits between the host/control logic and the FIR instance and is the only driver of its coefficient-load interface.

## Interface

**Parameters**
- `NTAPS`, 21: number of coefficients in the buffer; equals the FIR chain length.
- `W`, 16: coefficient width.
- `HALF`, 2: `coef_clk` low time and high time, in `clk` cycles; must be ≥1.
- `VERIFY_N`, 16: number of taps read back (indices 0..VERIFY_N-1); must be ≤16 (4-bit `sw`).

**Ports**
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  buffer write strobe.
- `wr_addr`  in  5  buffer index, 0..NTAPS-1.
- `wr_data`  in  W  coefficient to write.
- `start`  in  1  begin load + verify; single-cycle pulse.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse at end of operation.
- `error`  out  1  sticky readback-mismatch flag.
- `coef_out`  out  W  drives FIR `coef_in`.
- `coef_clk`  out  1  drives FIR `clk_coef`; registered, glitch-free.
- `sw`  out  4  drives FIR tap-select for readback.
- `coef_current`  in  W  FIR readback of coefficient `sw`.

## Operation

- **Reset values:** `busy`=0, `done`=0, `error`=0, `coef_out`=0, `coef_clk`=0, `sw`=0. State returns to IDLE. Buffer contents are not cleared by reset and are undefined until written.
- **Buffer writes:** `wr_en` writes `buf[wr_addr]` = `wr_data` only in IDLE. Writes are ignored while `busy`=1 and when `wr_addr` ≥ NTAPS.
- **IDLE:** `start`=1 moves to SHIFT, clears `error`, sets tap index k=NTAPS-1 and phase p=0. `start` is ignored in every state other than IDLE.
- **SHIFT:**
  - Each tap occupies 2·HALF cycles, with p counting 0..2·HALF-1.
  - `coef_out` ← `buf[k]`, loaded at p=0.
  - `coef_clk` = 1 when p ≥ HALF, otherwise 0.
  - Data is stable for HALF cycles before and HALF cycles after each rising edge of `coef_clk`.
  - Taps are sent in order `buf[NTAPS-1]` down to `buf[0]`, so FIR `coef[i]` = `buf[i]` after the last edge.
  - After the high phase of k=0, `coef_clk` returns to 0 and the state moves to VERIFY with i=0.
- **VERIFY:**
  - Each index uses 2 cycles: cycle A registers `sw`←i; cycle B samples `coef_current` and compares it with `buf[i]`.
  - On inequality, `error`←1; it stays set until the next accepted `start` or `reset`.
  - After i=VERIFY_N-1, move to DONE.
- **DONE:** `done`=1 and `busy`=0 for one cycle, then IDLE. `coef_out` and `sw` hold their last values.
- `coef_clk` has rising edges only in SHIFT, exactly NTAPS per operation.
- **Reset mid-operation:** aborts immediately. No further `coef_clk` edges and no `done`. The FIR chain is left partially shifted, and a later `start` reloads it fully.

## Timing

- Let edge 0 be the edge that samples `start`. `busy`=1 for cycles 1..NTAPS·2·HALF+2·VERIFY_N, i.e. 1..116 at defaults.
- Cycle 1 is p=0 of tap 20. The first `coef_clk` rise appears at cycle 1+HALF (cycle 3 at defaults).
- Tap j (j=0 is the first sent) rises at cycle 1+HALF+2·HALF·j.
- `done` pulses at cycle NTAPS·2·HALF+2·VERIFY_N+1 (117 at defaults).
- The readback path assumes the FIR's `coef_current` is combinational from `sw`, allowing one cycle of settle.

## Test plan

1. **Reset values.** Assert `reset` for 2 cycles → all outputs 0. No `coef_clk` edges for 20 cycles after release.
2. **Nominal load.** Write `buf[i]`=0x0100+i, pulse `start`, with a behavioural FIR chain model attached.
   - Exactly 21 `coef_clk` rises; `coef_out` at each rise is 0x0114, 0x0113, …, 0x0100.
   - Model `coef[i]`=0x0100+i.
   - `done` at cycle 117; `error`=0.
3. **Readback mismatch.** Same as 2, but the model forces `coef[5]`=0xBEEF → `error`=1 by `done` (cycle 117), held after. The next clean `start` clears it at cycle 1.
4. **Busy lockout.** Pulse `start` and `wr_en` (addr 3, data 0xFFFF) at cycle 40 → no restart, `done` still at 117, `buf[3]` unchanged. A write to addr 25 in IDLE has no effect.
5. **Reset mid-SHIFT.** Assert `reset` after the 7th `coef_clk` rise → `coef_clk`=0 and `busy`=0 next cycle, no `done`, no further edges. A fresh `start` produces a full 21 rises and `error`=0.
6. **HALF=1.** `coef_clk` period is 2 cycles, rises at cycles 2, 4, …, 42 → `done` at cycle 75.

Source files
------------

// File: rtl/fir_coef_loader_if.sv
// Host-side control bus of fir_coef_loader: coefficient buffer writes, start strobe and status.
interface fir_coef_loader_if #(
    parameter int W = 16
);
    logic         wr_en;
    logic [4:0]   wr_addr;
    logic [W-1:0] wr_data;
    logic         start;
    logic         busy;
    logic         done;
    logic         error;

    modport master (
        output wr_en, wr_addr, wr_data, start,
        input  busy, done, error
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start,
        output busy, done, error
    );
endinterface

// File: rtl/fir_coef_loader.sv
// Shifts a host-written coefficient buffer into the FIR coefficient chain over coef_in/clk_coef,
// then reads taps 0..VERIFY_N-1 back through sw/coef_current and flags any mismatch.
module fir_coef_loader #(
    parameter int NTAPS    = 21,
    parameter int W        = 16,
    parameter int HALF     = 2,
    parameter int VERIFY_N = 16
) (
    input  logic             clk,
    input  logic             reset,
    fir_coef_loader_if.slave host,
    output logic [W-1:0]     coef_out,
    output logic             coef_clk,
    output logic [3:0]       sw,
    input  logic [W-1:0]     coef_current
);
    localparam int            PW      = (2 * HALF > 1) ? $clog2(2 * HALF) : 1;
    localparam logic [PW-1:0] P_HIGH  = PW'(HALF);
    localparam logic [PW-1:0] P_LAST  = PW'(2 * HALF - 1);
    localparam logic [4:0]    K_FIRST = 5'(NTAPS - 1);
    localparam logic [3:0]    I_LAST  = 4'(VERIFY_N - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, VERIFY, DONE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    coef_buf [NTAPS];
    logic [4:0]      k;
    logic [PW-1:0]   p;
    logic [PW-1:0]   p_inc;
    logic [3:0]      i;
    logic            vb;
    logic            shift_last;
    logic            verify_last;

    assign p_inc       = p + PW'(1);
    assign shift_last  = (k == 5'd0) && (p == P_LAST);
    assign verify_last = vb && (i == I_LAST);

    // NOTE: the buffer is plain storage with no reset; a reset would turn it into a wide flop bank.
    always_ff @(posedge clk) begin
        if (host.wr_en && (state == IDLE) && (int'(host.wr_addr) < NTAPS))
            coef_buf[host.wr_addr] <= host.wr_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // NOTE: next state defaults to the current state so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (host.start) state_nxt = SHIFT;
            SHIFT:   if (shift_last) state_nxt = VERIFY;
            VERIFY:  if (verify_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        host.busy = (state == SHIFT) || (state == VERIFY);
        host.done = (state == DONE);
    end

    // Counters and FIR-facing outputs are registered one cycle ahead, so coef_clk is glitch-free
    // and coef_out is already settled during the p=0 cycle of each tap.
    always_ff @(posedge clk) begin
        if (reset) begin
            k          <= '0;
            p          <= '0;
            i          <= '0;
            vb         <= 1'b0;
            coef_out   <= '0;
            coef_clk   <= 1'b0;
            sw         <= '0;
            host.error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (host.start) begin
                        k          <= K_FIRST;
                        p          <= '0;
                        coef_out   <= coef_buf[K_FIRST];
                        coef_clk   <= 1'b0;
                        host.error <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (p == P_LAST) begin
                        p        <= '0;
                        coef_clk <= 1'b0;
                        if (k != 5'd0) begin
                            k        <= k - 5'd1;
                            coef_out <= coef_buf[k - 5'd1];
                        end else begin
                            i  <= '0;
                            vb <= 1'b0;
                        end
                    end else begin
                        p        <= p_inc;
                        coef_clk <= (p_inc >= P_HIGH);
                    end
                end
                VERIFY: begin
                    // vb=0: present the tap select; vb=1: the FIR readback has had a cycle to settle.
                    if (!vb) begin
                        sw <= i;
                        vb <= 1'b1;
                    end else begin
                        if (coef_current != coef_buf[{1'b0, i}])
                            host.error <= 1'b1;
                        vb <= 1'b0;
                        i  <= i + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_coef_loader.sv
// Self-checking bench for fir_coef_loader: table-driven operations, random buffers with a
// behavioural FIR chain, and a second instance at HALF=1.
module tb_fir_coef_loader;
    localparam int NTAPS    = 21;
    localparam int W        = 16;
    localparam int HALF     = 2;
    localparam int VERIFY_N = 16;
    localparam int BUSY_END = NTAPS * 2 * HALF + 2 * VERIFY_N;

    typedef struct {
        string name;
        int    corrupt;
        bit    lock;
        int    rst_rise;
        bit    exp_err;
        int    exp_done;
    } op_vec_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;
    int   force_tap;

    fir_coef_loader_if #(.W(W)) h  ();
    fir_coef_loader_if #(.W(W)) h1 ();

    logic [W-1:0] coef_out, coef_current;
    logic         coef_clk;
    logic [3:0]   sw;
    logic [W-1:0] h1_coef_out, h1_coef_current;
    logic         h1_coef_clk;
    logic [3:0]   h1_sw;

    logic [W-1:0] fir_q  [NTAPS];
    logic [W-1:0] fir1_q [NTAPS];
    logic [W-1:0] mbuf   [NTAPS];
    op_vec_t      vecs   [8];

    fir_coef_loader #(.NTAPS(NTAPS), .W(W), .HALF(HALF), .VERIFY_N(VERIFY_N)) dut (
        .clk(clk), .reset(reset), .host(h.slave),
        .coef_out(coef_out), .coef_clk(coef_clk), .sw(sw), .coef_current(coef_current)
    );

    fir_coef_loader #(.NTAPS(NTAPS), .W(W), .HALF(1), .VERIFY_N(VERIFY_N)) dut_h1 (
        .clk(clk), .reset(reset), .host(h1.slave),
        .coef_out(h1_coef_out), .coef_clk(h1_coef_clk), .sw(h1_sw), .coef_current(h1_coef_current)
    );

    // Behavioural FIR coefficient chains: shift in at coef[0] on each clk_coef rise.
    always @(posedge coef_clk) begin
        for (int j = NTAPS - 1; j > 0; j--) fir_q[j] <= fir_q[j-1];
        fir_q[0] <= coef_out;
    end
    always @(posedge h1_coef_clk) begin
        for (int j = NTAPS - 1; j > 0; j--) fir1_q[j] <= fir1_q[j-1];
        fir1_q[0] <= h1_coef_out;
    end
    assign coef_current    = (force_tap == int'(sw)) ? 16'hBEEF : fir_q[{1'b0, sw}];
    assign h1_coef_current = fir1_q[{1'b0, h1_sw}];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic host_write(input logic [4:0] a, input logic [W-1:0] d);
        h.wr_en   = 1'b1;
        h.wr_addr = a;
        h.wr_data = d;
        @(negedge clk);
        h.wr_en = 1'b0;
        if (int'(a) < NTAPS) mbuf[a] = d;
    endtask

    // Runs one start..done operation on the HALF=2 instance; called right after a negedge.
    task automatic run_op(input op_vec_t v);
        int   rises;
        int   done_at;
        int   rel;
        int   busy_bad;
        int   bad;
        int   quiet_rises;
        int   quiet_done;
        logic prev_clk;
        force_tap = v.corrupt;
        h.start = 1'b1;
        @(negedge clk);
        rises = 0; done_at = 0; busy_bad = 0; prev_clk = 1'b0; rel = 1;
        check({v.name, "/error_cleared"}, {31'd0, h.error}, 32'd0);
        while (rel <= 200) begin
            if (h.busy !== (rel <= BUSY_END)) busy_bad++;
            if (coef_clk && !prev_clk) begin
                check({v.name, "/rise_cycle"}, rel, 1 + HALF + 2 * HALF * rises);
                check({v.name, "/rise_data"}, {16'd0, coef_out}, {16'd0, mbuf[NTAPS-1-rises]});
                rises++;
                if (v.rst_rise != 0 && rises == v.rst_rise) begin
                    reset = 1'b1;
                    @(negedge clk);
                    reset = 1'b0;
                    check({v.name, "/abort_coef_clk"}, {31'd0, coef_clk}, 32'd0);
                    check({v.name, "/abort_busy"}, {31'd0, h.busy}, 32'd0);
                    quiet_rises = 0; quiet_done = 0; prev_clk = coef_clk;
                    repeat (40) begin
                        @(negedge clk);
                        if (coef_clk && !prev_clk) quiet_rises++;
                        if (h.done) quiet_done++;
                        prev_clk = coef_clk;
                    end
                    check({v.name, "/abort_rises"}, quiet_rises, 0);
                    check({v.name, "/abort_done"}, quiet_done, 0);
                    check({v.name, "/abort_error"}, {31'd0, h.error}, 32'd0);
                    return;
                end
            end
            prev_clk = coef_clk;
            if (h.done) begin
                done_at = rel;
                break;
            end
            h.start = 1'b0;
            h.wr_en = 1'b0;
            if (v.lock && rel == 40) begin
                h.start   = 1'b1;
                h.wr_en   = 1'b1;
                h.wr_addr = 5'd3;
                h.wr_data = 16'hFFFF;
            end
            @(negedge clk);
            rel++;
        end
        h.start = 1'b0;
        h.wr_en = 1'b0;
        check({v.name, "/done_cycle"}, done_at, v.exp_done);
        check({v.name, "/rise_count"}, rises, NTAPS);
        check({v.name, "/busy_window"}, busy_bad, 0);
        check({v.name, "/error_at_done"}, {31'd0, h.error}, {31'd0, v.exp_err});
        @(negedge clk);
        check({v.name, "/done_pulse_end"}, {31'd0, h.done}, 32'd0);
        check({v.name, "/error_held"}, {31'd0, h.error}, {31'd0, v.exp_err});
        bad = 0;
        for (int j = 0; j < NTAPS; j++) if (fir_q[j] !== mbuf[j]) bad++;
        check({v.name, "/fir_chain"}, bad, 0);
    endtask

    initial begin
        int      prises;
        int      rel;
        int      done_at;
        int      bad;
        logic    prev;
        op_vec_t rv;

        n_cmp = 0; n_fail = 0; force_tap = -1;
        reset = 1'b1;
        h.wr_en = 1'b0;  h.wr_addr = '0;  h.wr_data = '0;  h.start = 1'b0;
        h1.wr_en = 1'b0; h1.wr_addr = '0; h1.wr_data = '0; h1.start = 1'b0;

        vecs[0] = '{"nominal",    -1, 1'b0, 0, 1'b0, 117};
        vecs[1] = '{"mismatch5",   5, 1'b0, 0, 1'b1, 117};
        vecs[2] = '{"clean",      -1, 1'b0, 0, 1'b0, 117};
        vecs[3] = '{"lockout",    -1, 1'b1, 0, 1'b0, 117};
        vecs[4] = '{"mismatch15", 15, 1'b0, 0, 1'b1, 117};
        vecs[5] = '{"tap16_unchk",16, 1'b0, 0, 1'b0, 117};
        vecs[6] = '{"reset_mid",  -1, 1'b0, 7, 1'b0, 0};
        vecs[7] = '{"reload",     -1, 1'b0, 0, 1'b0, 117};

        // Reset values and quiet coef_clk after release.
        repeat (2) @(negedge clk);
        check("rst/busy", {31'd0, h.busy}, 32'd0);
        check("rst/done", {31'd0, h.done}, 32'd0);
        check("rst/error", {31'd0, h.error}, 32'd0);
        check("rst/coef_out", {16'd0, coef_out}, 32'd0);
        check("rst/coef_clk", {31'd0, coef_clk}, 32'd0);
        check("rst/sw", {28'd0, sw}, 32'd0);
        reset = 1'b0;
        prises = 0; prev = coef_clk;
        repeat (20) begin
            @(negedge clk);
            if (coef_clk && !prev) prises++;
            prev = coef_clk;
        end
        check("rst/quiet_rises", prises, 0);

        for (int j = 0; j < NTAPS; j++) host_write(5'(j), 16'(16'h0100 + j));

        for (int v = 0; v < 8; v++) begin
            if (v == 3) host_write(5'd25, 16'hDEAD);
            run_op(vecs[v]);
        end

        // Random buffers, random out-of-range writes and a random corrupted readback tap.
        for (int it = 0; it < 4; it++) begin
            repeat (8) host_write(5'($urandom_range(0, 31)), 16'($urandom_range(0, 16'hFFFF)));
            rv.name     = $sformatf("random%0d", it);
            rv.corrupt  = int'($urandom_range(0, NTAPS)) - 1;
            rv.lock     = 1'b0;
            rv.rst_rise = 0;
            rv.exp_err  = (rv.corrupt >= 0) && (rv.corrupt < VERIFY_N) && (mbuf[rv.corrupt] != 16'hBEEF);
            rv.exp_done = BUSY_END + 1;
            run_op(rv);
        end

        // HALF=1 instance: 2-cycle coef_clk period, rises at 2,4,..,42, done at 75.
        for (int j = 0; j < NTAPS; j++) begin
            h1.wr_en = 1'b1; h1.wr_addr = 5'(j); h1.wr_data = 16'(16'h0200 + j);
            @(negedge clk);
        end
        h1.wr_en = 1'b0;
        h1.start = 1'b1;
        @(negedge clk);
        h1.start = 1'b0;
        rel = 1; prises = 0; done_at = 0; bad = 0; prev = 1'b0;
        while (rel <= 150) begin
            if (h1_coef_clk && !prev) begin
                if (rel != 2 + 2 * prises || h1_coef_out !== 16'(16'h0200 + NTAPS - 1 - prises)) bad++;
                prises++;
            end
            prev = h1_coef_clk;
            if (h1.done) begin
                done_at = rel;
                break;
            end
            @(negedge clk);
            rel++;
        end
        check("half1/rise_count", prises, NTAPS);
        check("half1/rise_timing_data", bad, 0);
        check("half1/done_cycle", done_at, 75);
        check("half1/error", {31'd0, h1.error}, 32'd0);
        bad = 0;
        for (int j = 0; j < NTAPS; j++) if (fir1_q[j] !== 16'(16'h0200 + j)) bad++;
        check("half1/fir_chain", bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
